// File: rtl/montgomery_modexp.sv
// -----------------------------------------------------------------------------
// montgomery_modexp
//
// Purpose: 1024-bit modular exponentiation, result = msg^exp mod n, with a
// 16-bit exponent. The engine runs right-to-left binary exponentiation in the
// Montgomery domain (R = 2^1024) and uses two bit-serial Montgomery
// multipliers. m0 does the accumulate multiply and m1 does the square. Both
// multipliers are started in the same cycle, so the run time is constant and
// does not depend on the exponent value.
//
// Ports:
//   clk          rising-edge clock
//   resetn       asynchronous reset, ACTIVE-HIGH despite its name
//   start        one-cycle pulse, accepted only in IDLE or DONE
//   msg/exp/n    operands (msg < n, n odd)
//   rmodn        2^1024 mod n
//   r2modn       2^2048 mod n
//   result       msg^exp mod n, valid while done = 1
//   done         level, high from completion until next accepted start/reset
//   reg_start, cnt_out, e_out, m0_resetn, m1_resetn, m0_start, m1_start,
//   m0_in_a, m0_in_b   debug observation ports
//
// Configuration macro: MONT_EXP_DEBUG_EN
//   defined   -> debug ports are driven from the internal registers
//   undefined -> debug ports exist but are tied to 0 (datapath unchanged)
// -----------------------------------------------------------------------------

// Radix-2 bit-serial Montgomery multiplier: res = a*b*2^-1024 mod n.
// The start pulse is followed by 1024 iteration cycles and 1 subtract cycle.
// The done pulse comes 1026 cycles after start. a is captured at start, while
// b and n must stay stable until done.
module montgomery_modexp_mm (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_n,
    input  logic          start,
    input  logic [1023:0] a,
    input  logic [1023:0] b,
    input  logic [1023:0] n,
    output logic [1023:0] res,
    output logic          done
);
    logic [1025:0] s_r;
    logic [1025:0] t0_s;
    logic [1025:0] t1_s;
    logic [1025:0] s_step_s;
    logic [1025:0] s_sub_s;
    logic [1023:0] a_sh_r;
    logic [1023:0] res_r;
    logic [9:0]    iter_r;
    logic          busy_r;
    logic          sub_r;
    logic          done_r;

    // One Montgomery iteration. S stays below 2n, so S + b + n < 4n fits in 1026 bits.
    always_comb begin
        t0_s     = s_r + (a_sh_r[0] ? {2'b00, b} : 1026'd0);
        if (t0_s[0]) begin
            t1_s = t0_s + {2'b00, n};
        end else begin
            t1_s = t0_s;
        end
        s_step_s = {1'b0, t1_s[1025:1]};
        s_sub_s  = s_r - {2'b00, n};
    end

    // Iteration sequencer: load on start, 1024 shifts, then the final conditional subtract.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_r    <= 1026'd0;
            a_sh_r <= 1024'd0;
            res_r  <= 1024'd0;
            iter_r <= 10'd0;
            busy_r <= 1'b0;
            sub_r  <= 1'b0;
            done_r <= 1'b0;
        end else if (!clr_n) begin
            s_r    <= 1026'd0;
            a_sh_r <= 1024'd0;
            res_r  <= 1024'd0;
            iter_r <= 10'd0;
            busy_r <= 1'b0;
            sub_r  <= 1'b0;
            done_r <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (start) begin
                s_r    <= 1026'd0;
                a_sh_r <= a;
                iter_r <= 10'd0;
                busy_r <= 1'b1;
                sub_r  <= 1'b0;
            end else if (busy_r) begin
                s_r    <= s_step_s;
                a_sh_r <= {1'b0, a_sh_r[1023:1]};
                iter_r <= iter_r + 10'd1;
                if (iter_r == 10'd1023) begin
                    busy_r <= 1'b0;
                    sub_r  <= 1'b1;
                end
            end else if (sub_r) begin
                res_r  <= (s_r >= {2'b00, n}) ? s_sub_s[1023:0] : s_r[1023:0];
                done_r <= 1'b1;
                sub_r  <= 1'b0;
            end
        end
    end

    assign res  = res_r;
    assign done = done_r;
endmodule

module montgomery_modexp (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [1023:0] msg,
    input  logic [15:0]   exp,
    input  logic [1023:0] n,
    input  logic [1023:0] rmodn,
    input  logic [1023:0] r2modn,
    output logic [1023:0] result,
    output logic          done,
    output logic          reg_start,
    output logic [4:0]    cnt_out,
    output logic [15:0]   e_out,
    output logic          m0_resetn,
    output logic          m1_resetn,
    output logic          m0_start,
    output logic          m1_start,
    output logic [1023:0] m0_in_a,
    output logic [1023:0] m0_in_b
);
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_TOMONT   = 3'd1,
        ST_LOOP     = 3'd2,
        ST_FROMMONT = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_s;
    logic          accept_s;
    logic          issue_m0_s;
    logic          issue_m1_s;
    logic          last_round_s;
    logic          round_done_s;
    logic [1023:0] a_next_s;

    logic [4:0]    cnt_r;
    logic [15:0]   e_r;
    logic [1023:0] a_r;
    logic [1023:0] x_r;
    logic [1023:0] n_r;
    logic [1023:0] op_a_r;
    logic [1023:0] op_b_r;
    logic [1023:0] result_r;
    logic          done_r;
    logic          reg_start_r;
    logic          mul_clr_n_r;
    logic          m0_start_r;
    logic          m1_start_r;

    logic [1023:0] m0_res_s;
    logic [1023:0] m1_res_s;
    logic          m0_done_s;
    logic          m1_done_s;

    // m0 multiplies with the shared operand registers. m1 squares X.
    montgomery_modexp_mm u_m0 (
        .clk   (clk),
        .rst   (resetn),
        .clr_n (mul_clr_n_r),
        .start (m0_start_r),
        .a     (op_a_r),
        .b     (op_b_r),
        .n     (n_r),
        .res   (m0_res_s),
        .done  (m0_done_s)
    );

    montgomery_modexp_mm u_m1 (
        .clk   (clk),
        .rst   (resetn),
        .clr_n (mul_clr_n_r),
        .start (m1_start_r),
        .a     (x_r),
        .b     (x_r),
        .n     (n_r),
        .res   (m1_res_s),
        .done  (m1_done_s)
    );

    // Next-state and multiplier-issue decode.
    always_comb begin
        state_s      = state_r;
        accept_s     = 1'b0;
        issue_m0_s   = 1'b0;
        issue_m1_s   = 1'b0;
        last_round_s = (cnt_r == 5'd15);
        round_done_s = m0_done_s & m1_done_s;
        a_next_s     = e_r[0] ? m0_res_s : a_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_s  = ST_TOMONT;
                    accept_s = 1'b1;
                end else begin
                    state_s  = state_r;
                end
            end
            ST_TOMONT: begin
                // reg_start_r marks the first TOMONT cycle, when X = MM(msg, R^2) is kicked off
                if (reg_start_r) begin
                    issue_m0_s = 1'b1;
                end else if (m0_done_s) begin
                    state_s    = ST_LOOP;
                    issue_m0_s = 1'b1;
                    issue_m1_s = 1'b1;
                end else begin
                    state_s    = ST_TOMONT;
                end
            end
            ST_LOOP: begin
                if (round_done_s) begin
                    issue_m0_s = 1'b1;
                    if (last_round_s) begin
                        state_s    = ST_FROMMONT;
                    end else begin
                        issue_m1_s = 1'b1;
                    end
                end else begin
                    state_s = ST_LOOP;
                end
            end
            ST_FROMMONT: begin
                if (m0_done_s) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_FROMMONT;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath: operand latching, round updates and result capture.
    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            cnt_r       <= 5'd0;
            e_r         <= 16'd0;
            a_r         <= 1024'd0;
            x_r         <= 1024'd0;
            n_r         <= 1024'd0;
            op_a_r      <= 1024'd0;
            op_b_r      <= 1024'd0;
            result_r    <= 1024'd0;
            done_r      <= 1'b0;
            reg_start_r <= 1'b0;
            mul_clr_n_r <= 1'b0;
            m0_start_r  <= 1'b0;
            m1_start_r  <= 1'b0;
        end else begin
            reg_start_r <= accept_s;
            m0_start_r  <= issue_m0_s;
            m1_start_r  <= issue_m1_s;
            // Multipliers are held clear whenever the engine is not busy.
            mul_clr_n_r <= (state_s != ST_IDLE) && (state_s != ST_DONE);
            if (accept_s) begin
                n_r      <= n;
                e_r      <= exp;
                cnt_r    <= 5'd0;
                a_r      <= rmodn;
                op_a_r   <= msg;
                op_b_r   <= r2modn;
                done_r   <= 1'b0;
                result_r <= 1024'd0;
            end else if ((state_r == ST_TOMONT) && m0_done_s) begin
                x_r      <= m0_res_s;
                op_a_r   <= a_r;
                op_b_r   <= m0_res_s;
            end else if ((state_r == ST_LOOP) && round_done_s) begin
                a_r      <= a_next_s;
                x_r      <= m1_res_s;
                e_r      <= {1'b0, e_r[15:1]};
                cnt_r    <= cnt_r + 5'd1;
                op_a_r   <= a_next_s;
                // After the last round, m0 converts A out of the Montgomery domain with MM(A, 1).
                op_b_r   <= last_round_s ? 1024'd1 : m1_res_s;
            end else if ((state_r == ST_FROMMONT) && m0_done_s) begin
                result_r <= m0_res_s;
                done_r   <= 1'b1;
            end
        end
    end

    assign result = result_r;
    assign done   = done_r;

`ifdef MONT_EXP_DEBUG_EN
    assign reg_start = reg_start_r;
    assign cnt_out   = cnt_r;
    assign e_out     = e_r;
    assign m0_resetn = mul_clr_n_r;
    assign m1_resetn = mul_clr_n_r;
    assign m0_start  = m0_start_r;
    assign m1_start  = m1_start_r;
    assign m0_in_a   = op_a_r;
    assign m0_in_b   = op_b_r;
`else
    assign reg_start = 1'b0;
    assign cnt_out   = 5'd0;
    assign e_out     = 16'd0;
    assign m0_resetn = 1'b0;
    assign m1_resetn = 1'b0;
    assign m0_start  = 1'b0;
    assign m1_start  = 1'b0;
    assign m0_in_a   = 1024'd0;
    assign m0_in_b   = 1024'd0;
`endif

endmodule

// File: tb/tb_montgomery_modexp.sv
// -----------------------------------------------------------------------------
// tb_montgomery_modexp
//
// Self-checking bench for montgomery_modexp. A plain-arithmetic model
// (wide multiply and %) provides msg^exp mod n. A timeline model derived from
// the phase timing (18 phases of 1027 cycles) gives the expected done and
// debug outputs. One negedge process compares the DUT against both models on
// every cycle. Literal checks pin the model itself.
// -----------------------------------------------------------------------------
module tb_montgomery_modexp;
    localparam int RUN_CYC = 18487;
    localparam int PH      = 1027;

    logic          clk;
    logic          resetn;
    logic          start;
    logic [1023:0] msg;
    logic [15:0]   exp;
    logic [1023:0] n;
    logic [1023:0] rmodn;
    logic [1023:0] r2modn;
    logic [1023:0] result;
    logic          done;
    logic          reg_start;
    logic [4:0]    cnt_out;
    logic [15:0]   e_out;
    logic          m0_resetn;
    logic          m1_resetn;
    logic          m0_start;
    logic          m1_start;
    logic [1023:0] m0_in_a;
    logic [1023:0] m0_in_b;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Model state for the run currently in flight.
    bit            run_active = 1'b0;
    int            acc_cyc    = 0;
    logic [1023:0] exp_res;
    logic [15:0]   exp_e;
    logic [1023:0] exp_msg;
    logic [1023:0] exp_r2;
    logic [1023:0] big_n;
    logic [1023:0] big_msg;

    montgomery_modexp dut (
        .clk       (clk),
        .resetn    (resetn),
        .start     (start),
        .msg       (msg),
        .exp       (exp),
        .n         (n),
        .rmodn     (rmodn),
        .r2modn    (r2modn),
        .result    (result),
        .done      (done),
        .reg_start (reg_start),
        .cnt_out   (cnt_out),
        .e_out     (e_out),
        .m0_resetn (m0_resetn),
        .m1_resetn (m1_resetn),
        .m0_start  (m0_start),
        .m1_start  (m1_start),
        .m0_in_a   (m0_in_a),
        .m0_in_b   (m0_in_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [1023:0] act, input logic [1023:0] want);
        tests_run++;
        if (act !== want) begin
            tests_failed++;
            $display("FAIL %s: got %h want %h (low 128 bits) at cycle %0d",
                     nm, act[127:0], want[127:0], cyc);
        end
    endtask

    function automatic logic [1023:0] mulmod(input logic [1023:0] a, input logic [1023:0] b,
                                             input logic [1023:0] m);
        logic [2047:0] p;
        logic [2047:0] q;
        p = {1024'd0, a} * {1024'd0, b};
        q = p % {1024'd0, m};
        return q[1023:0];
    endfunction

    function automatic logic [1023:0] powmod(input logic [1023:0] base, input logic [15:0] e,
                                             input logic [1023:0] m);
        logic [1023:0] r;
        r = mulmod(1024'd1, 1024'd1, m);
        for (int i = 15; i >= 0; i--) begin
            r = mulmod(r, r, m);
            if (e[i]) r = mulmod(r, base, m);
        end
        return r;
    endfunction

    function automatic logic [1023:0] rmod(input logic [1023:0] m);
        logic [2047:0] t;
        logic [2047:0] q;
        t       = 2048'd0;
        t[1024] = 1'b1;
        q       = t % {1024'd0, m};
        return q[1023:0];
    endfunction

    // Issue an accepted start and load the model for it.
    task automatic launch(input logic [1023:0] m, input logic [15:0] e, input logic [1023:0] nn);
        @(posedge clk); #2;
        msg    = m;
        exp    = e;
        n      = nn;
        rmodn  = rmod(nn);
        r2modn = mulmod(rmodn, rmodn, nn);
        start  = 1'b1;
        @(posedge clk); #1;
        start      = 1'b0;
        acc_cyc    = cyc;
        run_active = 1'b1;
        exp_res    = powmod(m, e, nn);
        exp_e      = e;
        exp_msg    = m;
        exp_r2     = r2modn;
    endtask

    // Advance to 2 time units after edge acc_cyc + target.
    task automatic goto(input int target);
        while (cyc < acc_cyc + target) begin
            @(posedge clk); #1;
        end
        #1;
    endtask

`ifdef MONT_EXP_DEBUG_EN
    int both_cnt = 0;
`endif

    // Per-cycle comparison of the DUT against the model.
    always @(negedge clk) begin
        int   rel;
        int   k;
        logic exp_done_v;
        rel        = cyc - acc_cyc;
        exp_done_v = run_active && (rel >= RUN_CYC);
        chk("done", {1023'd0, done}, {1023'd0, exp_done_v});
        if (exp_done_v) begin
            chk("result", result, exp_res);
        end else if (!run_active) begin
            chk("result_idle", result, 1024'd0);
        end
`ifdef MONT_EXP_DEBUG_EN
        if (!run_active || rel < PH + 1) k = 0;
        else k = (rel - (PH + 1)) / PH;
        if (k > 16) k = 16;
        chk("cnt_out", {1019'd0, cnt_out}, k);
        chk("e_out", {1008'd0, e_out}, run_active ? {1008'd0, exp_e >> k} : 1024'd0);
        chk("reg_start", {1023'd0, reg_start}, (run_active && rel == 0) ? 1024'd1 : 1024'd0);
        chk("m_resetn", {1022'd0, m0_resetn, m1_resetn},
            (run_active && rel >= 0 && rel < RUN_CYC) ? 1024'd3 : 1024'd0);
        chk("m0_start", {1023'd0, m0_start},
            (run_active && rel >= 1 && (rel - 1) % PH == 0 && (rel - 1) / PH <= 17) ? 1024'd1 : 1024'd0);
        chk("m1_start", {1023'd0, m1_start},
            (run_active && rel >= 1 && (rel - 1) % PH == 0 && (rel - 1) / PH >= 1
             && (rel - 1) / PH <= 16) ? 1024'd1 : 1024'd0);
        if (run_active && rel == 0) both_cnt = 0;
        if (run_active && m0_start && m1_start) both_cnt++;
        if (run_active && rel == 1) begin
            chk("m0_in_a_tomont", m0_in_a, exp_msg);
            chk("m0_in_b_tomont", m0_in_b, exp_r2);
        end
        if (run_active && rel == 1 + 17 * PH) chk("m0_in_b_frommont", m0_in_b, 1024'd1);
        if (run_active && rel == RUN_CYC) chk("both_starts", both_cnt, 1024'd16);
`else
        chk("dbg_tied", {1000'd0, reg_start, cnt_out, e_out, m0_resetn, m1_resetn,
                         m0_start, m1_start, |m0_in_a, |m0_in_b}, 1024'd0);
`endif
    end

    initial begin
        logic [31:0] lcg;
        resetn = 1'b1;
        start  = 1'b0;
        msg    = 1024'd0;
        exp    = 16'd0;
        n      = 1024'd0;
        rmodn  = 1024'd0;
        r2modn = 1024'd0;

        lcg = 32'h1234_5678;
        for (int i = 0; i < 32; i++) begin
            lcg = lcg * 32'd1664525 + 32'd1013904223;
            big_n[i*32 +: 32] = lcg;
            lcg = lcg * 32'd1664525 + 32'd1013904223;
            big_msg[i*32 +: 32] = lcg;
        end
        big_n[1023:1008]   = 16'h8e7d;
        big_n[15:0]        = 16'hf9f7;
        big_msg[1023:1020] = 4'h0;

        // Pin the model against hand-computed values.
        chk("model_rmod13", rmod(1024'd13), 1024'd3);
        chk("model_r2mod13", mulmod(rmod(1024'd13), rmod(1024'd13), 1024'd13), 1024'd9);
        chk("model_2pow3", powmod(1024'd2, 16'd3, 1024'd13), 1024'd8);
        chk("model_5powffff", powmod(1024'd5, 16'hFFFF, 1024'd13), 1024'd8);
        chk("model_5pow0", powmod(1024'd5, 16'd0, 1024'd13), 1024'd1);
        chk("model_5pow1", powmod(1024'd5, 16'd1, 1024'd13), 1024'd5);

        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;
        repeat (2) @(posedge clk);

        // 2^3 mod 13 = 8, including done timing.
        launch(1024'd2, 16'd3, 1024'd13);
        goto(RUN_CYC - 1);
        chk("done_early", {1023'd0, done}, 1024'd0);
        goto(RUN_CYC);
        chk("done_2pow3", {1023'd0, done}, 1024'd1);
        chk("result_2pow3", result, 1024'd8);
`ifdef MONT_EXP_DEBUG_EN
        chk("cnt_2pow3", {1019'd0, cnt_out}, 1024'd16);
`endif

        // Restart from DONE: 5^0xFFFF mod 13 = 8.
        launch(1024'd5, 16'hFFFF, 1024'd13);
        goto(RUN_CYC);
        chk("result_5powffff", result, 1024'd8);

        // Full-width vector, with a start pulse and different operands mid-LOOP.
        launch(big_msg, 16'hb5df, big_n);
        goto(5000);
        msg   = big_n - 1024'd1;
        exp   = 16'h0003;
        n     = 1024'd13;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        goto(RUN_CYC);
        chk("result_big", result, powmod(big_msg, 16'hb5df, big_n));

        // Reset mid-LOOP aborts at once.
        launch(big_msg, 16'h1234, big_n);
        goto(1600);
        resetn     = 1'b1;
        run_active = 1'b0;
        #1;
        chk("abort_done", {1023'd0, done}, 1024'd0);
        chk("abort_result", result, 1024'd0);
        repeat (3) @(posedge clk);
        #2 resetn = 1'b0;

        // New run after abort: 5^0 mod 13 = 1.
        launch(1024'd5, 16'd0, 1024'd13);
        goto(RUN_CYC);
        chk("result_5pow0", result, 1024'd1);

        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
